// File: rtl/box_id_pkg.sv
// Shared types and defaults for the streaming box-ID pair/triplet checker.
package box_id_pkg;

  localparam int         ALPHABET_DEF  = 26;
  localparam logic [7:0] BASE_CHAR_DEF = 8'd97;

  // Letter bin: counts 0..3 exactly, 4 means "four or more".
  typedef logic [2:0] bin_t;
  localparam bin_t BIN_ZERO = 3'd0;
  localparam bin_t BIN_TWO  = 3'd2;
  localparam bin_t BIN_THREE = 3'd3;
  localparam bin_t BIN_SAT  = 3'd4;

  typedef enum logic {
    ACCUM = 1'b0,
    EVAL  = 1'b1
  } state_t;

  // Offset of a character from the first legal letter. Characters below the
  // base wrap to large values, so one unsigned compare decides legality.
  function automatic logic [8:0] char_offset(input logic [7:0] c, input logic [7:0] base);
    return {1'b0, c} - {1'b0, base};
  endfunction

endpackage

// File: rtl/letter_histogram.sv
// Per-letter saturating occurrence counters with "exactly two" / "exactly three" summaries.
module letter_histogram
  import box_id_pkg::*;
#(
  parameter int ALPHABET = ALPHABET_DEF,
  parameter int IDX_W    = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_has_two,
  output logic             o_has_three
);

  bin_t r_bins [ALPHABET];

  // Count one occurrence of the selected letter, holding at the saturation value.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < ALPHABET; i++) begin
      if (i_reset || i_clr) begin
        r_bins[i] <= BIN_ZERO;
      end else if (i_inc && (i_idx == IDX_W'(i)) && (r_bins[i] != BIN_SAT)) begin
        r_bins[i] <= r_bins[i] + 3'd1;
      end else begin
        r_bins[i] <= r_bins[i];
      end
    end
  end

  // Reduce all bins to the two flags the result stage needs.
  always_comb begin
    o_has_two   = 1'b0;
    o_has_three = 1'b0;
    for (int i = 0; i < ALPHABET; i++) begin
      o_has_two   = o_has_two   | (r_bins[i] == BIN_TWO);
      o_has_three = o_has_three | (r_bins[i] == BIN_THREE);
    end
  end

endmodule

// File: rtl/box_id_stream_checker.sv
// Streaming box-ID checker: histograms each ID, reports pair/triplet/error
// flags per ID and keeps saturating tallies plus their product as a checksum.
module box_id_stream_checker
  import box_id_pkg::*;
#(
  parameter int         ALPHABET   = ALPHABET_DEF,
  parameter logic [7:0] BASE_CHAR  = BASE_CHAR_DEF,
  parameter int         MAX_LEN    = 32,
  parameter int         TALLY_W    = 16,
  parameter int         CHECKSUM_W = 32   // must be at least 2*TALLY_W
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [7:0]            i_in_char,
  input  logic                  i_in_last,
  output logic                  o_id_valid,
  output logic                  o_id_pair,
  output logic                  o_id_triplet,
  output logic                  o_id_error,
  output logic [TALLY_W-1:0]    o_pair_count,
  output logic [TALLY_W-1:0]    o_triplet_count,
  output logic [CHECKSUM_W-1:0] o_checksum
);

  localparam int                IDX_W     = (ALPHABET > 1) ? $clog2(ALPHABET) : 1;
  localparam int                CNT_W     = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0]  MAX_LEN_C = CNT_W'(MAX_LEN);
  localparam logic [8:0]        ALPHA_C   = 9'(ALPHABET);
  localparam logic [TALLY_W-1:0] TALLY_MAX = {TALLY_W{1'b1}};

  state_t                 r_state;
  state_t                 w_next_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_err;
  logic                   r_id_valid;
  logic                   r_id_pair;
  logic                   r_id_triplet;
  logic                   r_id_error;
  logic [TALLY_W-1:0]     r_pair_count;
  logic [TALLY_W-1:0]     r_triplet_count;
  logic [CHECKSUM_W-1:0]  r_checksum;

  logic [8:0]             w_offset;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_legal;
  logic                   w_in_range;
  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_hist_inc;
  logic                   w_hist_clr;
  logic                   w_eval;
  logic                   w_has_two;
  logic                   w_has_three;

  // Decode the incoming beat: legality, length window, handshake and histogram controls.
  always_comb begin
    w_offset   = char_offset(i_in_char, BASE_CHAR);
    w_legal    = (w_offset < ALPHA_C);
    w_idx      = w_offset[IDX_W-1:0];
    w_in_range = (r_cnt < MAX_LEN_C);
    w_in_ready = (r_state == ACCUM) && !i_reset;
    // A beat presented together with clear is dropped.
    w_accept   = i_in_valid && w_in_ready && !i_clear;
    w_hist_inc = w_accept && w_legal && w_in_range;
    w_eval     = (r_state == EVAL);
    // The histogram empties on the same edge the result is captured.
    w_hist_clr = i_clear || w_eval;
  end

  // Next-state logic: one EVAL cycle follows every accepted last beat.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ACCUM: begin
        if (w_accept && i_in_last) begin
          w_next_state = EVAL;
        end else begin
          w_next_state = ACCUM;
        end
      end
      EVAL:    w_next_state = ACCUM;
      default: w_next_state = ACCUM;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Per-ID character index and sticky error for illegal or overlong input.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear || w_eval) begin
      r_cnt <= {CNT_W{1'b0}};
      r_err <= 1'b0;
    end else if (w_accept) begin
      if (r_cnt != MAX_LEN_C) begin
        r_cnt <= r_cnt + CNT_W'(1'b1);
      end
      if (!(w_legal && w_in_range)) begin
        r_err <= 1'b1;
      end
    end else begin
      r_cnt <= r_cnt;
      r_err <= r_err;
    end
  end

  // Result flags, saturating tallies and the checksum product.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_id_valid      <= 1'b0;
      r_id_pair       <= 1'b0;
      r_id_triplet    <= 1'b0;
      r_id_error      <= 1'b0;
      r_pair_count    <= {TALLY_W{1'b0}};
      r_triplet_count <= {TALLY_W{1'b0}};
      r_checksum      <= {CHECKSUM_W{1'b0}};
    end else if (i_clear) begin
      // A result pending in EVAL is discarded; the last reported flags stay.
      r_id_valid      <= 1'b0;
      r_pair_count    <= {TALLY_W{1'b0}};
      r_triplet_count <= {TALLY_W{1'b0}};
      r_checksum      <= {CHECKSUM_W{1'b0}};
    end else begin
      r_id_valid <= w_eval;
      if (w_eval) begin
        r_id_pair    <= w_has_two;
        r_id_triplet <= w_has_three;
        r_id_error   <= r_err;
        // Errored IDs report their flags but never count.
        if (!r_err && w_has_two && (r_pair_count != TALLY_MAX)) begin
          r_pair_count <= r_pair_count + TALLY_W'(1'b1);
        end
        if (!r_err && w_has_three && (r_triplet_count != TALLY_MAX)) begin
          r_triplet_count <= r_triplet_count + TALLY_W'(1'b1);
        end
      end
      // Tracks the tallies one cycle behind.
      r_checksum <= CHECKSUM_W'(r_pair_count) * CHECKSUM_W'(r_triplet_count);
    end
  end

  letter_histogram #(
    .ALPHABET (ALPHABET),
    .IDX_W    (IDX_W)
  ) u_hist (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clr       (w_hist_clr),
    .i_inc       (w_hist_inc),
    .i_idx       (w_idx),
    .o_has_two   (w_has_two),
    .o_has_three (w_has_three)
  );

  assign o_in_ready      = w_in_ready;
  assign o_id_valid      = r_id_valid;
  assign o_id_pair       = r_id_pair;
  assign o_id_triplet    = r_id_triplet;
  assign o_id_error      = r_id_error;
  assign o_pair_count    = r_pair_count;
  assign o_triplet_count = r_triplet_count;
  assign o_checksum      = r_checksum;

endmodule
